// File: rtl/handwriting_rx_pkg.sv
// Shared definitions for the handwriting_rx serial front end and the
// mnist_model inference core.
//   N_PIXELS : serial image bits per frame (28x28, 1 bit per pixel)
//   CNT_W    : bit-counter width, covers 0..N_PIXELS-1
//   DIGIT_W  : width of the classified digit (0-9)
//   state_t  : sequencer states
package handwriting_rx_pkg;

    localparam int N_PIXELS = 784;
    localparam int CNT_W    = 10;
    localparam int DIGIT_W  = 4;

    typedef enum logic [1:0] {
        RECV  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/handwriting_rx_mnist_model.sv
// mnist_model: inference core interface used by handwriting_rx.
// This is a small behavioural stand-in with the same port contract as the
// production core: it classifies an image as (number of set pixels) mod 10
// after a fixed multi-cycle latency.
// Ports:
//   clk        clock
//   rst        asynchronous reset, active-high
//   image_in   flattened image, pixel k at image_in[k]
//   start      sampled on rising clk, launches one inference
//   digit_out  classified digit, stable once valid is high
//   valid      rises after inference, stays high until reset
module mnist_model
    import handwriting_rx_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [N_PIXELS-1:0] image_in,
    input  logic                start,
    output logic [DIGIT_W-1:0]  digit_out,
    output logic                valid
);

    localparam int LAT = 6;

    logic [CNT_W-1:0] ones;
    logic [2:0]       lat_cnt;
    logic             running;

    always_comb begin
        ones = '0;
        for (int i = 0; i < N_PIXELS; i++) begin
            ones = ones + CNT_W'(image_in[i]);
        end
    end

    // One inference per reset: start is ignored once running or finished.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit_out <= '0;
            valid     <= 1'b0;
            lat_cnt   <= '0;
            running   <= 1'b0;
        end else if (start && !running && !valid) begin
            digit_out <= DIGIT_W'(ones % CNT_W'(10));
            lat_cnt   <= 3'(LAT);
            running   <= 1'b1;
        end else if (running) begin
            if (lat_cnt == 3'd0) begin
                running <= 1'b0;
                valid   <= 1'b1;
            end else begin
                lat_cnt <= lat_cnt - 3'd1;
            end
        end
    end

endmodule

// File: rtl/handwriting_rx.sv
// handwriting_rx: serial front end and sequencer for the MNIST classifier.
// A host streams one image bit per rising clk (bit 0 first); after the last
// bit the mnist_model core is started, and its digit is latched and flagged.
// A new frame requires reset. The clock may be stopped at any time; there is
// no time-based behaviour.
// Ports:
//   clk           sole clock, host-driven, may be gated or stopped
//   rst           asynchronous reset, active-low
//   data_in       serial pixel bit, sampled on rising clk
//   busy          high while inference is pending (registered)
//   digit_out     classified digit 0-9
//   result_valid  high when digit_out holds a completed result (registered)
module handwriting_rx
    import handwriting_rx_pkg::*;
#(
    parameter int N_PIXELS = handwriting_rx_pkg::N_PIXELS,
    parameter int CNT_W    = handwriting_rx_pkg::CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               data_in,
    output logic               busy,
    output logic [DIGIT_W-1:0] digit_out,
    output logic               result_valid
);

    state_t                state;
    logic [CNT_W-1:0]      cnt;
    logic [N_PIXELS-1:0]   image;
    logic                  core_start;
    logic [DIGIT_W-1:0]    core_digit;
    logic                  core_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= RECV;
            cnt          <= '0;
            image        <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b0;
            digit_out    <= '0;
            core_start   <= 1'b0;
        end else begin
            case (state)
                RECV: begin
                    image[cnt] <= data_in;
                    if (cnt == CNT_W'(N_PIXELS - 1)) begin
                        // busy and start rise on the capturing edge itself so
                        // a polling host never sees a gap between frame end
                        // and busy.
                        cnt        <= '0;
                        state      <= START;
                        busy       <= 1'b1;
                        core_start <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                START: begin
                    // core_valid is deliberately not looked at here; a stale
                    // flag from before start must not be taken as a result.
                    core_start <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (core_valid) begin
                        digit_out    <= core_digit;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    // Terminal until reset.
                end
                default: state <= RECV;
            endcase
        end
    end

    mnist_model u_core (
        .clk       (clk),
        .rst       (~rst),
        .image_in  (image),
        .start     (core_start),
        .digit_out (core_digit),
        .valid     (core_valid)
    );

endmodule

// File: tb/tb_handwriting_rx.sv
module tb_handwriting_rx;

    localparam int NP = 784;

    logic       clk = 1'b0;
    logic       clk_en = 1'b1;
    logic       rst = 1'b0;
    logic       data_in = 1'b0;
    logic       busy;
    logic [3:0] digit_out;
    logic       result_valid;

    int tests = 0;
    int failures = 0;

    logic [3:0] exp_q[$];

    handwriting_rx dut (
        .clk          (clk),
        .rst          (rst),
        .data_in      (data_in),
        .busy         (busy),
        .digit_out    (digit_out),
        .result_valid (result_valid)
    );

    // Gated clock: clk_en is only dropped while clk is low, so a stopped
    // clock rests low and resumes with a rising edge.
    always begin
        #5;
        if (clk_en) clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic logic [NP-1:0] ones_range(input int lo, input int hi);
        logic [NP-1:0] v;
        v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Scoreboard monitor: pops an expected digit on each rising result_valid.
    initial begin : monitor
        logic prev_rv;
        logic [3:0] exp_d;
        prev_rv = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) check("busy_and_valid_exclusive", {31'd0, busy & result_valid}, 32'd0);
            if (result_valid && !prev_rv) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    failures++;
                    $display("FAIL unexpected_result: got digit %0d, expected no result", digit_out);
                end else begin
                    exp_d = exp_q.pop_front();
                    check("digit_out", {28'd0, digit_out}, {28'd0, exp_d});
                    check("busy_at_result", {31'd0, busy}, 32'd0);
                end
            end
            prev_rv = result_valid;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_result_valid", {31'd0, result_valid}, 32'd0);
        check("rst_digit", {28'd0, digit_out}, 32'd0);
        check("rst_cnt", {22'd0, dut.cnt}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Streams one frame, bit 0 first. pause_at >= 0 stops the clock for
    // 100 ns before that bit is driven.
    task automatic send_frame(input logic [NP-1:0] img, input int pause_at);
        for (int k = 0; k < NP; k++) begin
            if (k == pause_at) begin
                @(negedge clk);
                clk_en = 1'b0;
                #100;
                check("paused_busy", {31'd0, busy}, 32'd0);
                clk_en = 1'b1;
            end
            data_in = img[k];
            if (k == NP - 1) begin
                check("busy_before_last", {31'd0, busy}, 32'd0);
                check("valid_before_last", {31'd0, result_valid}, 32'd0);
            end
            @(posedge clk);
            #1;
        end
        check("busy_after_last", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_result();
        int n;
        n = 0;
        while (!result_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (!result_valid) begin
            failures++;
            $display("FAIL result_timeout: got result_valid 0 after %0d cycles, expected 1", n);
        end
        @(negedge clk);
    endtask

    initial begin : stimulus
        logic [NP-1:0] f7, f2, f1, f0, f4, f17;
        logic [NP-1:0] one_img;
        f7  = ones_range(100, 106);              // 7 pixels  -> 7
        f2  = '0;
        f2[0] = 1'b1;
        f2[NP-1] = 1'b1;                         // both ends -> 2
        f1  = '0;
        f1[0] = 1'b1;                            // bit 0 only -> 1
        f0  = '0;                                // blank     -> 0
        f4  = '0;
        f4[200] = 1'b1; f4[300] = 1'b1;
        f4[400] = 1'b1; f4[500] = 1'b1;          // 4 pixels  -> 4
        f17 = ones_range(10, 26);                // 17 pixels -> 7
        one_img = '0;
        one_img[0] = 1'b1;

        #12;
        check("init_busy", {31'd0, busy}, 32'd0);
        check("init_result_valid", {31'd0, result_valid}, 32'd0);
        rst = 1'b1;

        do_reset();
        exp_q.push_back(4'd7);
        send_frame(f7, -1);
        wait_result();

        do_reset();
        exp_q.push_back(4'd2);
        send_frame(f2, -1);
        wait_result();

        // Bit order: only bit 0 set, clock stopped right after the last edge.
        do_reset();
        exp_q.push_back(4'd1);
        send_frame(f1, -1);
        @(negedge clk);
        clk_en = 1'b0;
        #20;
        tests++;
        if (dut.u_core.image_in !== one_img) begin
            failures++;
            $display("FAIL image_bit_order: got %0h, expected %0h", dut.u_core.image_in, one_img);
        end
        check("stopped_busy", {31'd0, busy}, 32'd1);
        #80;
        clk_en = 1'b1;
        wait_result();

        do_reset();
        exp_q.push_back(4'd0);
        send_frame(f0, -1);
        wait_result();

        do_reset();
        exp_q.push_back(4'd4);
        send_frame(f4, -1);
        wait_result();
        for (int i = 0; i < 50; i++) begin
            data_in = 1'($urandom);
            @(negedge clk);
            check("done_digit_hold", {28'd0, digit_out}, 32'd4);
            check("done_valid_hold", {31'd0, result_valid}, 32'd1);
            check("done_busy", {31'd0, busy}, 32'd0);
        end

        // Abort after 400 bits; the next frame must start at image[0].
        do_reset();
        for (int k = 0; k < 400; k++) begin
            data_in = 1'b1;
            @(posedge clk);
            #1;
        end
        do_reset();
        exp_q.push_back(4'd7);
        send_frame(f7, -1);
        wait_result();

        do_reset();
        exp_q.push_back(4'd7);
        send_frame(f17, -1);
        wait_result();

        // Same image as the uninterrupted f4 run, with a stopped clock mid-frame.
        do_reset();
        exp_q.push_back(4'd4);
        send_frame(f4, 300);
        wait_result();

        check("scoreboard_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
